// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared definitions for the pipelined carry-lookahead adder.
//   - SQRT_WIDTH / SQRT_BLOCK : default operand width and slice width used by
//     the square-root remainder-update datapath.
//   - cdiv(a, b)              : ceiling division, used to derive the number of
//     pipeline stages from WIDTH and BLOCK.
package pipelined_adder_pkg;

  localparam int SQRT_WIDTH = 17;
  localparam int SQRT_BLOCK = 4;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla.sv
// pipelined_cla_adder_cla
//   Combinational carry-lookahead adder for one pipeline slice.
//   Ports:
//     A_i  [WIDTH]  operand A slice
//     B_i  [WIDTH]  operand B slice (already inverted for subtraction)
//     Ci_i          carry into the slice
//     S_o  [WIDTH]  sum slice
//     Co_o          carry out of the slice
module pipelined_cla_adder_cla
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = SQRT_BLOCK
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Ci_i,
  output logic [WIDTH-1:0] S_o,
  output logic             Co_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             term;
  logic             run;

  assign gen  = A_i & B_i;
  assign prop = A_i ^ B_i;

  // Each carry is expanded in flattened sum-of-products form from the slice
  // carry-in, so no carry depends on another carry of the same slice.
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    run      = 1'b0;
    carry[0] = Ci_i;
    for (int i = 0; i < WIDTH; i++) begin
      term = gen[i];
      run  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (run & gen[j]);
        run  = run & prop[j];
      end
      carry[i+1] = term | (run & Ci_i);
    end
  end

  assign S_o  = prop ^ carry[WIDTH-1:0];
  assign Co_o = carry[WIDTH];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. The operand is cut into
//   BLOCK-bit slices; stage k resolves slice k with the carry registered by
//   stage k-1. Upper operand slices are skewed forward, lower sum slices are
//   carried along (deskewed) so the full result leaves the last stage at once.
//   Latency is ceil(WIDTH/BLOCK) cycles, throughput one beat per cycle.
//   A single global enable (en = ~valid_o | ready_i) advances every stage.
//   Optional feature macro: PIPE_ADDER_OVF_EN adds the signed overflow output.
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     valid_i / ready_o  operand handshake (ready_o depends on ready_i, valid_o)
//     A_i, B_i           operands
//     Ci_i               carry-in (ignored when sub_i=1)
//     sub_i              1: A-B, 0: A+B+Ci
//     valid_o / ready_i  result handshake
//     S_o, Co_o          result and carry-out (subtract: 1 = no borrow)
//     ovf_o              signed overflow (PIPE_ADDER_OVF_EN only)
module pipelined_cla_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH,
  parameter int BLOCK = SQRT_BLOCK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Ci_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] S_o,
  output logic             Co_o
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int NUM_STAGES = cdiv(WIDTH, BLOCK);
  localparam int LAST_W     = WIDTH - (NUM_STAGES - 1) * BLOCK;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_in;

  assign en      = ~valid_o | ready_i;
  assign ready_o = en;
  assign b_eff   = sub_i ? ~B_i : B_i;
  assign c_in    = sub_i | Ci_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    localparam int SW   = (k == NUM_STAGES - 1) ? LAST_W : BLOCK;
    localparam int HI_W = k * BLOCK + SW;

    logic [SW-1:0]   sa;
    logic [SW-1:0]   sb;
    logic            cin;
    logic [SW-1:0]   cs;
    logic            cout;
    logic            vld_src;
    logic [HI_W-1:0] s_nxt;
    logic [HI_W-1:0] s_p;
    logic            c_p;
    logic            vld_p;

    if (k == 0) begin : g_src
      assign sa      = A_i[SW-1:0];
      assign sb      = b_eff[SW-1:0];
      assign cin     = c_in;
      assign vld_src = valid_i;
      assign s_nxt   = cs;
    end else begin : g_src
      assign sa      = g_stg[k-1].g_opnd.a_p[SW-1:0];
      assign sb      = g_stg[k-1].g_opnd.b_p[SW-1:0];
      assign cin     = g_stg[k-1].c_p;
      assign vld_src = g_stg[k-1].vld_p;
      assign s_nxt   = {cs, g_stg[k-1].s_p};
    end

    pipelined_cla_adder_cla #(
      .WIDTH (SW)
    ) u_cla (
      .A_i  (sa),
      .B_i  (sb),
      .Ci_i (cin),
      .S_o  (cs),
      .Co_o (cout)
    );

    // ---- stage k register boundary: sum slices 0..k, carry, valid ----
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s_p   <= '0;
        c_p   <= 1'b0;
        vld_p <= 1'b0;
      end else if (en) begin
        s_p   <= s_nxt;
        c_p   <= cout;
        vld_p <= vld_src;
      end
    end

    if (k < NUM_STAGES - 1) begin : g_opnd
      localparam int UW = WIDTH - (k + 1) * BLOCK;

      logic [UW-1:0] a_nxt;
      logic [UW-1:0] b_nxt;
      logic [UW-1:0] a_p;
      logic [UW-1:0] b_p;

      if (k == 0) begin : g_skw
        assign a_nxt = A_i[WIDTH-1:BLOCK];
        assign b_nxt = b_eff[WIDTH-1:BLOCK];
      end else begin : g_skw
        assign a_nxt = g_stg[k-1].g_opnd.a_p[WIDTH-k*BLOCK-1:BLOCK];
        assign b_nxt = g_stg[k-1].g_opnd.b_p[WIDTH-k*BLOCK-1:BLOCK];
      end

      // ---- stage k register boundary: skewed operand slices k+1.. ----
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_p <= '0;
          b_p <= '0;
        end else if (en) begin
          a_p <= a_nxt;
          b_p <= b_nxt;
        end
      end
    end
  end

  assign S_o     = g_stg[NUM_STAGES-1].s_p;
  assign Co_o    = g_stg[NUM_STAGES-1].c_p;
  assign valid_o = g_stg[NUM_STAGES-1].vld_p;

`ifdef PIPE_ADDER_OVF_EN
  // The carry into the MSB is recovered from the MSB sum bit:
  // s = a ^ b ^ c_in_msb, so c_in_msb = a ^ b ^ s.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic s_msb, input logic c_out);
    return (a_msb ^ b_msb ^ s_msb) ^ c_out;
  endfunction

  logic ovf_p;

  // ---- last stage register boundary: overflow aligned with S_o ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_p <= 1'b0;
    end else if (en) begin
      ovf_p <= ovf_calc(g_stg[NUM_STAGES-1].sa[LAST_W-1],
                        g_stg[NUM_STAGES-1].sb[LAST_W-1],
                        g_stg[NUM_STAGES-1].cs[LAST_W-1],
                        g_stg[NUM_STAGES-1].cout);
    end
  end

  assign ovf_o = ovf_p;
`endif

endmodule
